// File: rtl/fifo_pkg.sv
// Shared constants and types for the synchronous FWFT FIFO controller.
package fifo_pkg;

    localparam int unsigned D_WIDTH_DEF = 8;
    localparam int unsigned A_WIDTH_DEF = 4;
    localparam int unsigned DEPTH       = 2 ** A_WIDTH_DEF;
    localparam int unsigned SKID_DEPTH  = 2;

    typedef logic [A_WIDTH_DEF+1:0] level_t;

endpackage

// File: rtl/sync_ram_simple_dual.sv
// Simple dual-port synchronous RAM: one write port, one read port with registered output.
module sync_ram_simple_dual #(
    parameter int unsigned d_width = 8,
    parameter int unsigned a_width = 4
) (
    input  logic               clk,
    input  logic               i_we,
    input  logic [a_width-1:0] i_waddr,
    input  logic [d_width-1:0] i_wdata,
    input  logic               i_re,
    input  logic [a_width-1:0] i_raddr,
    output logic [d_width-1:0] o_rdata
);

    logic [d_width-1:0] r_mem [2**a_width];
    logic [d_width-1:0] r_rdata;

    // Array is never reset; the controller only consumes read data it issued.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/fifo_ctrl_sync.sv
// FWFT valid/ready FIFO: RAM pointer control plus a 2-entry skid buffer hiding RAM read latency.
module fifo_ctrl_sync
    import fifo_pkg::*;
#(
    parameter int unsigned d_width = D_WIDTH_DEF,
    parameter int unsigned a_width = A_WIDTH_DEF
) (
    input  logic               clk,
    input  logic               nrst,
    input  logic               flush,
    input  logic [d_width-1:0] in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [d_width-1:0] out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [a_width+1:0] level
);

    localparam int unsigned RAM_DEPTH = 2 ** a_width;
    localparam int unsigned CNT_W     = a_width + 1;
    localparam int unsigned LVL_W     = a_width + 2;

    logic [a_width-1:0] r_wr_ptr;
    logic [a_width-1:0] r_rd_ptr;
    logic [CNT_W-1:0]   r_count_ram;
    logic               r_rd_pending;
    logic [1:0]         r_occ;
    logic [d_width-1:0] r_skid0;
    logic [d_width-1:0] r_skid1;
    logic               r_out_valid;
    logic [LVL_W-1:0]   r_level;

    logic               w_push;
    logic               w_pop;
    logic               w_rd_issue;
    logic [2:0]         w_occ_pend;
    logic [1:0]         w_occ_after_pop;
    logic [a_width-1:0] w_wr_ptr_n;
    logic [a_width-1:0] w_rd_ptr_n;
    logic [CNT_W-1:0]   w_count_n;
    logic [1:0]         w_occ_n;
    logic [d_width-1:0] w_skid0_n;
    logic [d_width-1:0] w_skid1_n;
    logic [LVL_W-1:0]   w_level_n;
    logic [d_width-1:0] w_ram_rdata;

    // Ready depends only on registered RAM occupancy, never on out_ready.
    assign in_ready = nrst & (r_count_ram != CNT_W'(RAM_DEPTH));
    assign w_push   = in_valid & in_ready;
    assign w_pop    = r_out_valid & out_ready;

    sync_ram_simple_dual #(
        .d_width (d_width),
        .a_width (a_width)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_push & ~flush),
        .i_waddr (r_wr_ptr),
        .i_wdata (in_data),
        .i_re    (w_rd_issue),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_ram_rdata)
    );

    always_comb begin
        w_occ_pend      = 3'(r_occ) + 3'(r_rd_pending) - 3'(w_pop);
        w_rd_issue      = (r_count_ram != '0) && (w_occ_pend <= 3'd1);
        w_occ_after_pop = r_occ - 2'(w_pop);

        w_wr_ptr_n = r_wr_ptr + a_width'(w_push);
        w_rd_ptr_n = r_rd_ptr + a_width'(w_rd_issue);
        w_count_n  = r_count_ram + CNT_W'(w_push) - CNT_W'(w_rd_issue);
        w_occ_n    = w_occ_after_pop + 2'(r_rd_pending);

        w_skid0_n = r_skid0;
        w_skid1_n = r_skid1;
        // Shift only from a full skid so an emptied head keeps its last value.
        if (w_pop && (r_occ == 2'(SKID_DEPTH))) begin
            w_skid0_n = r_skid1;
        end
        if (r_rd_pending) begin
            if (w_occ_after_pop == 2'd0) begin
                w_skid0_n = w_ram_rdata;
            end else begin
                w_skid1_n = w_ram_rdata;
            end
        end

        w_level_n = LVL_W'(w_count_n) + LVL_W'(w_rd_issue) + LVL_W'(w_occ_n);
    end

    always_ff @(posedge clk) begin
        if (!nrst || flush) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count_ram  <= '0;
            r_rd_pending <= 1'b0;
            r_occ        <= '0;
            r_skid0      <= '0;
            r_skid1      <= '0;
            r_out_valid  <= 1'b0;
            r_level      <= '0;
        end else begin
            r_wr_ptr     <= w_wr_ptr_n;
            r_rd_ptr     <= w_rd_ptr_n;
            r_count_ram  <= w_count_n;
            r_rd_pending <= w_rd_issue;
            r_occ        <= w_occ_n;
            r_skid0      <= w_skid0_n;
            r_skid1      <= w_skid1_n;
            r_out_valid  <= (w_occ_n != 2'd0);
            r_level      <= w_level_n;
        end
    end

    assign out_data  = r_skid0;
    assign out_valid = r_out_valid;
    assign level     = r_level;

endmodule

// File: tb/tb_fifo_ctrl_sync.sv
// Self-checking bench for fifo_ctrl_sync: queue-based reference model plus directed literal checks.
module tb_fifo_ctrl_sync;

    localparam int unsigned DW  = 8;
    localparam int unsigned AW  = 4;
    localparam int          RD  = 16;
    localparam int          CAP = 18;

    logic          clk = 1'b0;
    logic          nrst;
    logic          flush;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic [AW+1:0] level;

    int n_cmp = 0;
    int n_err = 0;
    bit check_en = 1'b0;

    // Reference model: one ordered queue of stored words, split by how many sit
    // in the RAM, how many are in the read pipe, and how many are at the output.
    int           m_cram = 0;
    int           m_pend = 0;
    int           m_occ  = 0;
    logic [7:0]   m_q[$];
    logic [7:0]   popped[$];
    int           push_cnt = 0;

    always #5 clk = ~clk;

    fifo_ctrl_sync #(.d_width(DW), .a_width(AW)) dut (
        .clk       (clk),
        .nrst      (nrst),
        .flush     (flush),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .level     (level)
    );

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        bit push;
        bit pop;
        bit issue;
        if (!nrst || flush) begin
            m_cram = 0;
            m_pend = 0;
            m_occ  = 0;
            m_q.delete();
        end else begin
            push  = in_valid && (m_cram < RD);
            pop   = out_ready && (m_occ != 0);
            issue = (m_cram != 0) && (m_occ + m_pend - int'(pop) <= 1);
            if (pop) popped.push_back(m_q.pop_front());
            if (push) begin
                m_q.push_back(in_data);
                push_cnt++;
            end
            m_cram = m_cram + int'(push) - int'(issue);
            m_occ  = m_occ + m_pend - int'(pop);
            m_pend = int'(issue);
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            check("in_ready", int'(in_ready), int'(nrst && (m_cram < RD)));
            check("out_valid", int'(out_valid), int'(m_occ != 0));
            check("level", int'(level), m_cram + m_pend + m_occ);
            check("level_cap", int'(int'(level) <= CAP), 1);
            if (m_occ != 0 && m_q.size() > 0) check("out_data", int'(out_data), int'(m_q[0]));
        end
    end

    // Present inputs for one rising edge, return just after it.
    task automatic drive(input bit v, input logic [7:0] d, input bit r, input bit f, input bit n = 1'b1);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        flush     = f;
        nrst      = n;
        @(posedge clk);
        #1;
    endtask

    initial begin
        nrst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        repeat (3) drive(1'b1, 8'h55, 1'b1, 1'b0, 1'b0);
        check("rst_in_ready", int'(in_ready), 0);
        nrst = 1'b1;
        #1;
        check_en = 1'b1;
        check("idle_out_valid", int'(out_valid), 0);
        check("idle_level", int'(level), 0);
        check("idle_in_ready", int'(in_ready), 1);
        check("idle_out_data", int'(out_data), 0);

        // Single word latency
        drive(1'b1, 8'hA5, 1'b0, 1'b0);
        check("lat_level_e0", int'(level), 1);
        check("lat_valid_e0", int'(out_valid), 0);
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        check("lat_valid_e1", int'(out_valid), 0);
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        check("lat_valid_e2", int'(out_valid), 1);
        check("lat_data_e2", int'(out_data), 8'hA5);
        check("lat_level_e2", int'(level), 1);
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        check("lat_pop_level", int'(level), 0);
        check("lat_pop_valid", int'(out_valid), 0);

        // Fill to capacity with the consumer stalled
        push_cnt = 0;
        for (int i = 0; i < 22; i++) drive(1'b1, 8'(push_cnt), 1'b0, 1'b0);
        check("full_level", int'(level), CAP);
        check("full_in_ready", int'(in_ready), 0);
        check("full_accepts", push_cnt, CAP);

        // Drain: one word per cycle from the first pop
        popped.delete();
        for (int i = 0; i < CAP; i++) drive(1'b0, 8'h00, 1'b1, 1'b0);
        check("drain_count", popped.size(), CAP);
        for (int i = 0; i < popped.size(); i++) check("drain_order", int'(popped[i]), i);
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        check("drain_level", int'(level), 0);
        check("drain_valid", int'(out_valid), 0);

        // Streaming ramp across pointer wrap
        popped.delete();
        push_cnt = 0;
        for (int i = 0; i < 103; i++) drive(i < 100, 8'(i), 1'b1, 1'b0);
        check("ramp_accepts", push_cnt, 100);
        check("ramp_count", popped.size(), 100);
        for (int i = 0; i < popped.size(); i++) check("ramp_order", int'(popped[i]), i);

        // Random traffic with occasional flush and reset
        for (int i = 0; i < 10000; i++) begin
            drive(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 511) == 0), ($urandom_range(0, 1023) != 0));
        end

        // Flush with a simultaneous push and pop
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 7; i++) drive(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
        repeat (3) drive(1'b0, 8'h00, 1'b0, 1'b0);
        check("pre_flush_level", int'(level), 7);
        popped.delete();
        drive(1'b1, 8'h99, 1'b1, 1'b1);
        check("flush_level", int'(level), 0);
        check("flush_valid", int'(out_valid), 0);
        check("flush_in_ready", int'(in_ready), 1);
        drive(1'b1, 8'h3C, 1'b0, 1'b0);
        repeat (2) drive(1'b0, 8'h00, 1'b0, 1'b0);
        check("post_flush_valid", int'(out_valid), 1);
        check("post_flush_data", int'(out_data), 8'h3C);
        check("post_flush_level", int'(level), 1);
        check("flush_no_pop", popped.size(), 0);

        check_en = 1'b0;
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fifo_ctrl_sync.md
Name: fifo_ctrl_sync

Overview:
- Synchronous FWFT valid/ready FIFO. Storage is an internal simple dual-port synchronous RAM with registered read output and 1-cycle read latency.
- The block generates the RAM write/read addresses and write enable, and hides read latency with a 2-entry output skid buffer.
- Sits between a streaming producer (e.g. pixel/sample source) and its consumer; decouples bursts.
- Total capacity: 2**a_width RAM entries + 2 skid entries.

Parameters:
- d_width, 8, data word width
- a_width, 4, RAM address width; RAM depth = 2**a_width

Ports:
- clk  in  1  single clock, all state on rising edge
- nrst  in  1  reset, synchronous, active-low
- flush  in  1  synchronous clear of FIFO contents (RAM array not cleared)
- in_data  in  d_width  write data
- in_valid  in  1  producer offers in_data
- in_ready  out  1  FIFO accepts; push = in_valid & in_ready
- out_data  out  d_width  head word (skid entry 0)
- out_valid  out  1  head word valid
- out_ready  in  1  consumer takes; pop = out_valid & out_ready
- level  out  a_width+2  total stored words = count_ram + rd_pending + occ_out

Behaviour:
- State: wr_ptr, rd_ptr (a_width bits, natural wrap 2**a_width-1 -> 0), count_ram (0..2**a_width), rd_pending (1 bit), occ_out (0..2), skid[0..1].
- Reset (nrst=0 at edge): all pointers/counters 0, rd_pending 0, occ_out 0, skid regs 0. Hence out_valid=0, out_data=0, level=0. in_ready=0 while nrst=0, 1 otherwise when count_ram < 2**a_width.
- Push: RAM we = push; address_w = wr_ptr; wr_ptr += 1.
- Read issue (combinational): rd_issue = (count_ram != 0) && (occ_out + rd_pending - pop <= 1). address_r = rd_ptr; on rd_issue, rd_ptr += 1. rd_pending <= rd_issue.
- count_ram <= count_ram + push - rd_issue. Push and issue can occur in the same cycle.
- Capture: when rd_pending=1, RAM data_out is written into the first free skid slot after applying pop. On pop, skid[1] shifts to skid[0]. occ_out <= occ_out + rd_pending - pop. occ_out never exceeds 2.
- Latency: a push accepted at edge E into an empty FIFO gives out_valid=1 after edge E+2, with out_data = that word.
- Throughput: 1 word/cycle sustained with in_valid=out_ready=1 held.
- No read-during-write hazard. rd_ptr==wr_ptr only when the RAM is empty (no issue) or full (in_ready=0).
- Full: count_ram = 2**a_width gives in_ready=0. A pop frees RAM space only through a subsequent rd_issue; in_ready rises the cycle after that issue. No combinational ready path from out_ready.
- Empty: out_valid=0 and out_data holds its last value. Consumer must ignore out_data.
- Order: strict FIFO, no loss/duplication across wrap.
- flush=1 at edge: same state clear as reset. A push or pop in that cycle is discarded and in-flight reads are dropped. in_ready stays valid during flush.
- nrst has priority over flush. Reset mid-stream discards all contents; data is never replayed.

Decomposition:
- Package fifo_pkg: localparam DEPTH = 2**a_width, the skid depth constant 2, and a typedef for the level type (a_width+2 bits).
- One sub-module: the team's simple dual-port sync RAM (sync_ram_simple_dual), instantiated with d_width/a_width.
- Skid buffer and pointer logic stay in this module.

Test Plan:
- Reset then idle -> out_valid=0, level=0, in_ready=1; a push of 0xA5 at edge E -> out_valid=1 and out_data=0xA5 after E+2; level=1.
- Push 0x00..0x11 (18 words, a_width=4) with out_ready=0 -> in_ready falls after 18 accepts, level=18; further in_valid ignored.
- From that full state, out_ready=1 -> words 0x00..0x11 pop in order, one per cycle after the first; level reaches 0, out_valid=0.
- Continuous push/pop of a 0..99 ramp with in_valid=out_ready=1 -> 1 word/cycle after a 2-cycle fill; output ramp exact across pointer wrap.
- Random in_valid/out_ready (50%) for 10k cycles against a scoreboard -> no loss, no duplication, level always matches the model, never >18.
- flush=1 while level=7 with a push and pop asserted -> next cycle level=0, out_valid=0; a new push of 0x3C is the next word out.
